// File: rtl/axi_ad7763_cfg_fifo_if.sv
// AXI4-Lite slave channel bundle for the AD7763 control-word FIFO.
// The master modport is the PS-side initiator; the slave modport is the register block.
interface axi_ad7763_cfg_fifo_if #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 12
);
  logic [AXI_ADDR_WIDTH-1:0] awaddr;
  logic                      awvalid;
  logic                      awready;
  logic [AXI_DATA_WIDTH-1:0] wdata;
  logic                      wvalid;
  logic                      wready;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;
  logic [AXI_ADDR_WIDTH-1:0] araddr;
  logic                      arvalid;
  logic                      arready;
  logic [AXI_DATA_WIDTH-1:0] rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_ad7763_cfg_fifo.sv
// AXI4-Lite control-word FIFO that serialises words to an AD7763-class ADC (fsin pulse + MSB-first sdi).
// Optional irq output and STATUS[4]/CTRL[2] support are enabled by defining AXI_AD7763_CFG_IRQ_EN.
module axi_ad7763_cfg_fifo #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 12,
  parameter int WORD_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int FS_LEN         = 1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  axi_ad7763_cfg_fifo_if.slave  s_axi,
  input  logic                  adc_sco,
  output logic                  adc_fsin,
  output logic                  adc_sdi
`ifdef AXI_AD7763_CFG_IRQ_EN
  ,
  output logic                  irq
`endif
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int BIT_W = $clog2(WORD_WIDTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, FSYNC, SHIFT} state_t;

  logic [WORD_WIDTH-1:0] mem [FIFO_DEPTH];

  state_t                    state_reg, state_next;
  logic [WORD_WIDTH-1:0]     shift_reg, shift_next;
  logic [3:0]                fs_cnt_reg, fs_cnt_next;
  logic [BIT_W-1:0]          bit_cnt_reg, bit_cnt_next;
  logic                      fsin_reg, fsin_next;
  logic                      sdi_reg, sdi_next;
  logic                      sco_meta_reg, sco_sync_reg, sco_prev_reg;
  logic [PTR_W-1:0]          wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
  logic [LVL_W-1:0]          level_reg, level_next;
  logic                      enable_reg, enable_next;
  logic                      ovf_reg, ovf_next;
  logic                      aw_held_reg, aw_held_next, w_held_reg, w_held_next;
  logic [1:0]                awaddr_reg, awaddr_next;
  logic [AXI_DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic                      awready_reg, awready_next, wready_reg, wready_next;
  logic                      bvalid_reg, bvalid_next;
  logic [1:0]                bresp_reg, bresp_next;
  logic                      arready_reg, arready_next, rvalid_reg, rvalid_next;
  logic [1:0]                rresp_reg, rresp_next;
  logic [AXI_DATA_WIDTH-1:0] rdata_reg, rdata_next, status_word;
  logic                      sco_rise, empty, full, busy, wr_fire, push, pop, flush, ovf_set;
  logic                      irq_bit;

  assign sco_rise = sco_sync_reg & ~sco_prev_reg;
  assign empty    = (level_reg == '0);
  assign full     = (level_reg == LVL_W'(FIFO_DEPTH));
  assign busy     = (state_reg != IDLE) || !empty;
  assign wr_fire  = aw_held_reg & w_held_reg & ~bvalid_reg;

  // Serial engine: every state change is qualified by the synchronised sco rising edge.
  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    fs_cnt_next  = fs_cnt_reg;
    bit_cnt_next = bit_cnt_reg;
    fsin_next    = fsin_reg;
    sdi_next     = sdi_reg;
    pop          = 1'b0;
    if (sco_rise) begin
      case (state_reg)
        IDLE: begin
          if (enable_reg && !empty) begin
            pop         = 1'b1;
            shift_next  = mem[rd_ptr_reg];
            fsin_next   = 1'b0;
            fs_cnt_next = 4'(FS_LEN - 1);
            state_next  = FSYNC;
          end else begin
            sdi_next = 1'b0;
          end
        end
        FSYNC: begin
          if (fs_cnt_reg == '0) begin
            fsin_next    = 1'b1;
            sdi_next     = shift_reg[WORD_WIDTH-1];
            bit_cnt_next = BIT_W'(WORD_WIDTH - 1);
            state_next   = SHIFT;
          end else begin
            fs_cnt_next = fs_cnt_reg - 4'd1;
          end
        end
        SHIFT: begin
          shift_next = {shift_reg[WORD_WIDTH-2:0], 1'b0};
          if (bit_cnt_reg == '0) begin
            sdi_next   = 1'b0;
            state_next = IDLE;
          end else begin
            sdi_next     = shift_reg[WORD_WIDTH-2];
            bit_cnt_next = bit_cnt_reg - BIT_W'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Write path: AW and W latch independently; the register action fires once both are held.
  always_comb begin
    aw_held_next = aw_held_reg;
    w_held_next  = w_held_reg;
    awaddr_next  = awaddr_reg;
    wdata_next   = wdata_reg;
    bvalid_next  = bvalid_reg;
    bresp_next   = bresp_reg;
    enable_next  = enable_reg;
    push         = 1'b0;
    flush        = 1'b0;
    ovf_set      = 1'b0;
    if (s_axi.awvalid && awready_reg) begin
      aw_held_next = 1'b1;
      awaddr_next  = s_axi.awaddr[3:2];
    end
    if (s_axi.wvalid && wready_reg) begin
      w_held_next = 1'b1;
      wdata_next  = s_axi.wdata;
    end
    if (wr_fire) begin
      aw_held_next = 1'b0;
      w_held_next  = 1'b0;
      bvalid_next  = 1'b1;
      bresp_next   = RESP_OKAY;
      case (awaddr_reg)
        2'd0: begin
          // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
          if (!full || pop) push = 1'b1;
          else begin
            ovf_set    = 1'b1;
            bresp_next = RESP_SLVERR;
          end
        end
        2'd2: begin
          enable_next = wdata_reg[0];
          flush       = wdata_reg[1];
        end
        2'd3:    bresp_next = RESP_SLVERR;
        default: ;
      endcase
    end else if (bvalid_reg && s_axi.bready) begin
      bvalid_next = 1'b0;
    end
    awready_next = !aw_held_next && !bvalid_next;
    wready_next  = !w_held_next && !bvalid_next;
  end

  // FIFO bookkeeping; a flush drops queued words but never the one already in the shifter.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    level_next  = level_reg;
    ovf_next    = ovf_reg | ovf_set;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      level_next  = '0;
      ovf_next    = 1'b0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      level_next = level_reg + LVL_W'(push) - LVL_W'(pop);
    end
  end

`ifdef AXI_AD7763_CFG_IRQ_EN
  logic irq_reg, irq_next;
  always_comb begin
    irq_next = irq_reg;
    if (wr_fire && awaddr_reg == 2'd2 && wdata_reg[2]) irq_next = 1'b0;
    if (ovf_set || (state_reg == SHIFT && state_next == IDLE && level_next == '0))
      irq_next = 1'b1;
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) irq_reg <= 1'b0;
    else          irq_reg <= irq_next;
  end
  assign irq_bit = irq_reg;
  assign irq     = irq_reg;
`else
  assign irq_bit = 1'b0;
`endif

  always_comb begin
    status_word       = '0;
    status_word[0]    = busy;
    status_word[1]    = empty;
    status_word[2]    = full;
    status_word[3]    = ovf_reg;
    status_word[4]    = irq_bit;
    status_word[15:8] = 8'(level_reg);
  end

  always_comb begin
    rvalid_next = rvalid_reg;
    rdata_next  = rdata_reg;
    rresp_next  = rresp_reg;
    if (s_axi.arvalid && arready_reg) begin
      rvalid_next = 1'b1;
      rdata_next  = '0;
      rresp_next  = RESP_OKAY;
      case (s_axi.araddr[3:2])
        2'd1:    rdata_next = status_word;
        2'd2:    rdata_next[0] = enable_reg;
        2'd3:    rresp_next = RESP_SLVERR;
        default: ;
      endcase
    end else if (rvalid_reg && s_axi.rready) begin
      rvalid_next = 1'b0;
    end
    arready_next = !rvalid_next;
  end

  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr_reg] <= wdata_reg[WORD_WIDTH-1:0];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      fs_cnt_reg   <= '0;
      bit_cnt_reg  <= '0;
      fsin_reg     <= 1'b1;
      sdi_reg      <= 1'b0;
      sco_meta_reg <= 1'b0;
      sco_sync_reg <= 1'b0;
      sco_prev_reg <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      enable_reg   <= 1'b1;
      ovf_reg      <= 1'b0;
      aw_held_reg  <= 1'b0;
      w_held_reg   <= 1'b0;
      awaddr_reg   <= '0;
      wdata_reg    <= '0;
      awready_reg  <= 1'b0;
      wready_reg   <= 1'b0;
      bvalid_reg   <= 1'b0;
      bresp_reg    <= RESP_OKAY;
      arready_reg  <= 1'b0;
      rvalid_reg   <= 1'b0;
      rresp_reg    <= RESP_OKAY;
      rdata_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      fs_cnt_reg   <= fs_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      fsin_reg     <= fsin_next;
      sdi_reg      <= sdi_next;
      sco_meta_reg <= adc_sco;
      sco_sync_reg <= sco_meta_reg;
      sco_prev_reg <= sco_sync_reg;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      level_reg    <= level_next;
      enable_reg   <= enable_next;
      ovf_reg      <= ovf_next;
      aw_held_reg  <= aw_held_next;
      w_held_reg   <= w_held_next;
      awaddr_reg   <= awaddr_next;
      wdata_reg    <= wdata_next;
      awready_reg  <= awready_next;
      wready_reg   <= wready_next;
      bvalid_reg   <= bvalid_next;
      bresp_reg    <= bresp_next;
      arready_reg  <= arready_next;
      rvalid_reg   <= rvalid_next;
      rresp_reg    <= rresp_next;
      rdata_reg    <= rdata_next;
    end
  end

  assign s_axi.awready = awready_reg;
  assign s_axi.wready  = wready_reg;
  assign s_axi.bvalid  = bvalid_reg;
  assign s_axi.bresp   = bresp_reg;
  assign s_axi.arready = arready_reg;
  assign s_axi.rvalid  = rvalid_reg;
  assign s_axi.rresp   = rresp_reg;
  assign s_axi.rdata   = rdata_reg;
  assign adc_fsin      = fsin_reg;
  assign adc_sdi       = sdi_reg;
endmodule
